// File: rtl/rv32i_fetch_pkg.sv
// Shared types and constants for the RV32I prefetching fetch stage.
package rv32i_fetch_pkg;
    localparam logic [31:0] NOOP_INSTRUCTION = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/rv32i_fetch_fifo.sv
// Show-ahead FIFO of {pc, instr} pairs; flush beats push and pop.
module rv32i_fetch_fifo
    import rv32i_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             din,
    output fetch_entry_t             head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW:0]    rd_ptr;
    logic [AW:0]    wr_ptr;
    logic           do_push;
    logic           do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/rv32i_prefetch_fetch_unit.sv
// RV32I fetch stage: valid/ready request port, in-order responses, prefetch
// queue towards decode, redirect flush with squashing of stale responses.
module rv32i_prefetch_fetch_unit
    import rv32i_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic                                   i_branch_miss,
    input  logic [31:0]                            i_branch_pc,
    output logic                                   o_mem_req_valid,
    input  logic                                   i_mem_req_ready,
    output logic [31:0]                            o_mem_req_addr,
    input  logic                                   i_mem_rsp_valid,
    input  logic [31:0]                            i_mem_rsp_data,
    output logic                                   o_instr_valid,
    input  logic                                   i_decode_ready,
    output logic [31:0]                            o_instr,
    output logic [31:0]                            o_instr_pc,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   o_outstanding
);
    localparam int OW = $clog2(MAX_OUTSTANDING+1);
    localparam int CW = $clog2(FIFO_DEPTH)+1;

    logic [31:0]    fetch_pc;
    logic [31:0]    rsp_pc;
    logic [OW-1:0]  outstanding;
    logic [OW-1:0]  drop_cnt;
    logic           fifo_empty;
    logic           fifo_full;
    logic [CW-1:0]  fifo_count;
    fetch_entry_t   head;
    logic           req_fire;
    logic           rsp_keep;
    logic           pop;
    logic [31:0]    reserved;

    // Queue slots already promised to live in-flight requests count as used.
    assign reserved = 32'(outstanding) - 32'(drop_cnt) + 32'(fifo_count);

    assign o_mem_req_valid = !i_rst && !i_branch_miss
                          && (32'(outstanding) < MAX_OUTSTANDING)
                          && (reserved < FIFO_DEPTH);
    assign o_mem_req_addr  = fetch_pc;
    assign req_fire        = o_mem_req_valid && i_mem_req_ready;
    assign rsp_keep        = i_mem_rsp_valid && (drop_cnt == '0) && !i_branch_miss;
    assign pop             = o_instr_valid && i_decode_ready && !i_branch_miss;

    assign o_instr_valid   = !fifo_empty;
    assign o_instr         = fifo_empty ? NOOP_INSTRUCTION : head.instr;
    assign o_instr_pc      = fifo_empty ? rsp_pc : head.pc;
    assign o_outstanding   = outstanding;

    rv32i_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (rsp_keep),
        .pop   (pop),
        .flush (i_branch_miss),
        .din   ('{pc: rsp_pc, instr: i_mem_rsp_data}),
        .head  (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + OW'(req_fire) - OW'(i_mem_rsp_valid);
            if (i_branch_miss) begin
                fetch_pc <= {i_branch_pc[31:2], 2'b00};
                rsp_pc   <= {i_branch_pc[31:2], 2'b00};
                // Every request still in flight after this cycle is stale.
                drop_cnt <= outstanding - OW'(i_mem_rsp_valid);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + 32'd4;
                if (i_mem_rsp_valid) begin
                    if (drop_cnt != '0) drop_cnt <= drop_cnt - OW'(1);
                    else                rsp_pc   <= rsp_pc + 32'd4;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (drop_cnt <= outstanding);
            assert (!(rsp_keep && fifo_full && !pop));
        end
    end
endmodule
